// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction queue that decouples the IF stage from the ID stage.
// A flush or a taken branch (br_cancel) discards every buffered packet.
// Build option: define IF_ID_QUEUE_BYPASS_EN to forward IF straight to ID when the queue is empty.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 112
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         if_to_q_valid,
  input  logic [WIDTH-1:0]             if_to_q_bus,
  output logic                         q_allowin,
  output logic                         q_to_id_valid,
  output logic [WIDTH-1:0]             q_to_id_bus,
  input  logic                         id_allowin,
  input  logic                         flush,
  input  logic                         br_cancel,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count;

  logic cancel;
  logic push;
  logic pop;
  logic pop_mem;
  logic bypass;

  // Handshake and head selection; a full queue refuses input even when ID pops.
  always_comb begin
    cancel    = flush | br_cancel;
    q_allowin = ~reset & (count != CW'(DEPTH));
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass        = ~reset & (count == CW'(0)) & if_to_q_valid & ~cancel;
    q_to_id_valid = ((count != CW'(0)) | bypass) & ~cancel;
    q_to_id_bus   = bypass ? if_to_q_bus : mem[rptr];
    pop           = q_to_id_valid & id_allowin;
    // A bypassed packet consumed by ID this cycle never enters storage.
    pop_mem       = pop & ~bypass;
    push          = if_to_q_valid & q_allowin & ~cancel & ~(bypass & id_allowin);
`else
    bypass        = 1'b0;
    q_to_id_valid = (count != CW'(0)) & ~cancel;
    q_to_id_bus   = mem[rptr];
    pop           = q_to_id_valid & id_allowin;
    pop_mem       = pop;
    push          = if_to_q_valid & q_allowin & ~cancel;
`endif
    q_count = count;
  end

  // Packet storage; contents are never cleared, only pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= if_to_q_bus;
    end
  end

  // Pointer and occupancy update; cancel empties the queue at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= AW'(0);
      wptr  <= AW'(0);
      count <= CW'(0);
    end else if (cancel) begin
      rptr  <= AW'(0);
      wptr  <= AW'(0);
      count <= CW'(0);
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_mem) begin
        rptr <= rptr + AW'(1);
      end
      if (push & ~pop_mem) begin
        count <= count + CW'(1);
      end else if (~push & pop_mem) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed stimulus with a scoreboard of expected queue contents.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 112;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             if_to_q_valid;
  logic [WIDTH-1:0] if_to_q_bus;
  logic             q_allowin;
  logic             q_to_id_valid;
  logic [WIDTH-1:0] q_to_id_bus;
  logic             id_allowin;
  logic             flush;
  logic             br_cancel;
  logic [CW-1:0]    q_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int               mcount;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_to_q_valid (if_to_q_valid),
    .if_to_q_bus   (if_to_q_bus),
    .q_allowin     (q_allowin),
    .q_to_id_valid (q_to_id_valid),
    .q_to_id_bus   (q_to_id_bus),
    .id_allowin    (id_allowin),
    .flush         (flush),
    .br_cancel     (br_cancel),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  // {inst, pc, excep_en, ecode, esubcode, badv}
  function automatic logic [WIDTH-1:0] pkt(input logic [31:0] pc);
    return {pc ^ 32'h0280_0c00, pc, 1'b0, 6'd0, 9'd0, pc ^ 32'h0000_ffff};
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the scoreboard, advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic ida,
                      input logic fl, input logic bc, output logic accepted);
    logic             cancel, e_allow, e_valid, e_byp, e_pop, e_push;
    logic [WIDTH-1:0] e_head;
    if_to_q_valid = v;
    if_to_q_bus   = pkt(pc);
    id_allowin    = ida;
    flush         = fl;
    br_cancel     = bc;
    #1;
    cancel  = fl | bc;
    e_allow = (mcount != DEPTH);
    e_byp   = BYP && (mcount == 0) && v && !cancel;
    e_valid = ((mcount != 0) || e_byp) && !cancel;
    e_head  = e_byp ? pkt(pc) : (mcount != 0 ? exp_q[0] : '0);
    chk("allowin", WIDTH'(q_allowin), WIDTH'(e_allow));
    chk("valid",   WIDTH'(q_to_id_valid), WIDTH'(e_valid));
    chk("count",   WIDTH'(q_count), WIDTH'(mcount));
    if (e_valid) chk("head", q_to_id_bus, e_head);
    e_pop  = e_valid && ida;
    e_push = v && e_allow && !cancel && !(e_byp && ida);
    accepted = v && e_allow && !cancel;
    @(posedge clk);
    if (cancel) begin
      exp_q.delete();
    end else begin
      if (e_pop && !e_byp) void'(exp_q.pop_front());
      if (e_push) exp_q.push_back(pkt(pc));
    end
    mcount = exp_q.size();
    @(negedge clk);
  endtask

  task automatic idle(input logic ida);
    logic acc;
    step(1'b0, 32'hdead_0000, ida, 1'b0, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    logic [31:0] pc;
    int guard;

    reset = 1'b1; if_to_q_valid = 1'b0; if_to_q_bus = '0;
    id_allowin = 1'b0; flush = 1'b0; br_cancel = 1'b0;
    mcount = 0;
    #1;
    chk("rst_valid",   WIDTH'(q_to_id_valid), WIDTH'(0));
    chk("rst_count",   WIDTH'(q_count), WIDTH'(0));
    chk("rst_allowin", WIDTH'(q_allowin), WIDTH'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_allowin", WIDTH'(q_allowin), WIDTH'(1));

    // Fill to DEPTH with ID stalled, then offer a fifth.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1c00_0010, 1'b0, 1'b0, 1'b0, acc);
    chk("fifth_refused", WIDTH'(acc), WIDTH'(0));
    chk("full_count", WIDTH'(q_count), WIDTH'(4));
    // Release ID; keep offering 0x10 until it is taken.
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 8) begin
      step(1'b1, 32'h1c00_0010, 1'b1, 1'b0, 1'b0, acc);
      guard++;
    end
    chk("fifth_accepted", WIDTH'(acc), WIDTH'(1));
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("drained", WIDTH'(q_count), WIDTH'(0));

    // Streaming push and pop.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h1c00_1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, acc);
      if (i > 0) chk("stream_count", WIDTH'(q_count), WIDTH'(BYP ? 0 : 1));
    end
    for (int i = 0; i < 2; i++) idle(1'b1);

    // br_cancel with three queued and a push offered.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c00_2000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1c00_200c, 1'b0, 1'b0, 1'b1, acc);
    chk("bc_count", WIDTH'(q_count), WIDTH'(0));
    idle(1'b0);
    step(1'b1, 32'h1c00_0100, 1'b0, 1'b0, 1'b0, acc);
    chk("bc_head", q_to_id_bus, pkt(32'h1c00_0100));
    idle(1'b1);

    // flush and br_cancel together while ID is ready.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c00_3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, acc);
    chk("fb_count", WIDTH'(q_count), WIDTH'(0));
    idle(1'b1);

    // Asynchronous reset mid-stream with two entries.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c00_4000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
    if_to_q_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",   WIDTH'(q_to_id_valid), WIDTH'(0));
    chk("mid_rst_count",   WIDTH'(q_count), WIDTH'(0));
    chk("mid_rst_allowin", WIDTH'(q_allowin), WIDTH'(0));
    exp_q.delete();
    mcount = 0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'h1c00_5000, 1'b0, 1'b0, 1'b0, acc);
    chk("post_rst_head", q_to_id_bus, pkt(32'h1c00_5000));
    idle(1'b1);

    // Empty queue, packet offered with ID ready.
    pc = 32'h1c00_0200;
    if_to_q_valid = 1'b1; if_to_q_bus = pkt(pc); id_allowin = 1'b1;
    #1;
    chk("byp_valid", WIDTH'(q_to_id_valid), WIDTH'(BYP));
    if (BYP) chk("byp_bus", q_to_id_bus, pkt(pc));
    step(1'b1, pc, 1'b1, 1'b0, 1'b0, acc);
    chk("byp_count", WIDTH'(q_count), WIDTH'(BYP ? 0 : 1));
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
